// File: rtl/snake_pkg.sv
// Shared constants and types for the snake board LED matrix path.
package snake_pkg;

   localparam int MATRIX_ROWS = 8;
   localparam int MATRIX_COLS = 16;

   typedef logic [MATRIX_COLS-1:0] row_pixels_t;

   typedef enum logic [0:0] {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scan_state_t;

   localparam logic [MATRIX_ROWS-1:0] ROW_OFF = 8'hFF;
   localparam row_pixels_t            COL_OFF = 16'hFFFF;

   // Active-low one-hot row select for the given row index.
   function automatic logic [MATRIX_ROWS-1:0] row_select_n(input logic [2:0] row);
      return ~(8'b1 << row);
   endfunction

endpackage

// File: rtl/led_matrix_scanner_frame_buffer_dp.sv
// Double-buffered 8x16 framebuffer: writes go to the back bank, reads come from the front bank.
module frame_buffer_dp
   import snake_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        front_sel,
   input  logic        wr_en,
   input  logic [2:0]  wr_row,
   input  row_pixels_t wr_data,
   input  logic [2:0]  rd_row,
   output row_pixels_t rd_data
);

   row_pixels_t bank_a [MATRIX_ROWS];
   row_pixels_t bank_b [MATRIX_ROWS];

   // front_sel=0 displays bank A, so the back bank is B.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MATRIX_ROWS; i++) begin
            bank_a[i] <= '0;
            bank_b[i] <= '0;
         end
      end else if (wr_en) begin
         if (front_sel) bank_a[wr_row] <= wr_data;
         else           bank_b[wr_row] <= wr_data;
      end
   end

   assign rd_data = front_sel ? bank_b[rd_row] : bank_a[rd_row];

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexing scan controller for the 8x16 active-low LED matrix with
// blank gaps between rows and frame-boundary buffer swaps.
module led_matrix_scanner
   import snake_pkg::*;
#(
   parameter int DWELL_CYCLES = 1000,
   parameter int BLANK_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [2:0]  wr_row,
   input  logic [15:0] wr_data,
   input  logic        swap_req,
   output logic        swap_ack,
   output logic        frame_start,
   output logic [7:0]  output_row,
   output logic [15:0] output_col
);

   localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   scan_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       row;
   logic             front_sel;
   logic             swap_pending;
   row_pixels_t      front_pixels;

   frame_buffer_dp u_fb (
      .clk       (clk),
      .rst_n     (rst_n),
      .front_sel (front_sel),
      .wr_en     (wr_en),
      .wr_row    (wr_row),
      .wr_data   (wr_data),
      .rd_row    (row),
      .rd_data   (front_pixels)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= BLANK;
         cnt          <= '0;
         row          <= '0;
         front_sel    <= 1'b0;
         swap_pending <= 1'b0;
         swap_ack     <= 1'b0;
         frame_start  <= 1'b0;
         output_row   <= ROW_OFF;
         output_col   <= COL_OFF;
      end else begin
         swap_ack    <= 1'b0;
         frame_start <= 1'b0;
         if (swap_req) swap_pending <= 1'b1;

         unique case (state)
            BLANK: begin
               if (cnt == BLANK_LAST) begin
                  state       <= DRIVE;
                  cnt         <= '0;
                  output_row  <= row_select_n(row);
                  output_col  <= ~front_pixels;
                  frame_start <= (row == 3'd0);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DRIVE: begin
               if (cnt == DWELL_LAST) begin
                  state      <= BLANK;
                  cnt        <= '0;
                  row        <= row + 3'd1;
                  output_row <= ROW_OFF;
                  output_col <= COL_OFF;
                  // Leaving row 7 is the frame boundary; a request landing on it is honoured here.
                  if (row == 3'd7 && (swap_pending || swap_req)) begin
                     front_sel    <= ~front_sel;
                     swap_pending <= 1'b0;
                     swap_ack     <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= BLANK;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner with a 4-cycle dwell and 2-cycle blank (48-cycle frame).
module tb_led_matrix_scanner;

   localparam int DW    = 4;
   localparam int BK    = 2;
   localparam int ROWP  = DW + BK;
   localparam int FRAME = 8 * ROWP;
   localparam int NV    = 10;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        wr_en    = 1'b0;
   logic [2:0]  wr_row   = 3'd0;
   logic [15:0] wr_data  = 16'h0;
   logic        swap_req = 1'b0;
   logic        swap_ack;
   logic        frame_start;
   logic [7:0]  output_row;
   logic [15:0] output_col;

   led_matrix_scanner #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BK)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_row      (wr_row),
      .wr_data     (wr_data),
      .swap_req    (swap_req),
      .swap_ack    (swap_ack),
      .frame_start (frame_start),
      .output_row  (output_row),
      .output_col  (output_col)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: edge count since reset release plus the two buffers.
   int          n = 0;
   logic        m_sel = 1'b0;
   logic        m_pend = 1'b0;
   logic        m_ack = 1'b0;
   logic [15:0] m_a [8];
   logic [15:0] m_b [8];
   int          sb_q [$];
   int          ack_cnt = 0;
   bit          mon_en = 1'b0;

   typedef struct {
      bit          we;
      logic [2:0]  row;
      logic [15:0] data;
      int          nswap;
      bit          bnd;
      int          off;
      logic [2:0]  chk_row;
      logic [15:0] chk_col;
      int          acks;
   } vec_t;

   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at edge %0d: got %h expected %h", name, n, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_row(input int e);
      if (e < 2 || ((e - 2) % ROWP) >= DW) return 8'hFF;
      return 8'hFF ^ (8'h01 << (((e - 2) / ROWP) % 8));
   endfunction

   function automatic logic [15:0] exp_col(input int e);
      logic [2:0] ri;
      if (e < 2 || ((e - 2) % ROWP) >= DW) return 16'hFFFF;
      ri = 3'(((e - 2) / ROWP) % 8);
      return m_sel ? ~m_b[ri] : ~m_a[ri];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n = 0; m_sel = 1'b0; m_pend = 1'b0; m_ack = 1'b0;
         for (int i = 0; i < 8; i++) begin
            m_a[i] = 16'h0;
            m_b[i] = 16'h0;
         end
         sb_q.delete();
      end else begin
         n = n + 1;
         m_ack = 1'b0;
         if (wr_en) begin
            if (m_sel) m_a[wr_row] = wr_data;
            else       m_b[wr_row] = wr_data;
         end
         if ((n % FRAME) == 0 && (m_pend || swap_req)) begin
            m_sel  = ~m_sel;
            m_pend = 1'b0;
            m_ack  = 1'b1;
         end else if (swap_req) begin
            m_pend = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("row", 32'(output_row), 32'(exp_row(n)));
         chk("col", 32'(output_col), 32'(exp_col(n)));
         chk("frame_start", 32'(frame_start), 32'(n >= 2 && ((n - 2) % FRAME) == 0));
         chk("swap_ack", 32'(swap_ack), 32'(m_ack));
         if (swap_ack === 1'b1) begin
            ack_cnt++;
            if (sb_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL sb_unexpected_ack at edge %0d: got ack, expected none", n);
            end else begin
               chk("sb_ack_edge", 32'(n), 32'(sb_q.pop_front()));
            end
         end else if (sb_q.size() > 0 && sb_q[0] < n) begin
            tests++; fails++;
            $display("FAIL sb_missing_ack at edge %0d: got none, expected ack at edge %0d", n, sb_q[0]);
            void'(sb_q.pop_front());
         end
      end
   end

   task automatic goto(input int e);
      int budget;
      budget = 0;
      if (n > e) begin
         tests++; fails++;
         $display("FAIL goto at edge %0d: got past target, expected edge %0d", n, e);
      end
      while (n < e && budget < 5000) begin
         @(posedge clk);
         #1;
         budget++;
      end
      if (n < e) begin
         tests++; fails++;
         $display("FAIL goto_timeout: got edge %0d, expected edge %0d", n, e);
      end
   endtask

   // Holds the given inputs across exactly edge e.
   task automatic pulse(input int e, input bit we, input logic [2:0] row,
                        input logic [15:0] data, input bit sw);
      goto(e - 1);
      wr_en = we; wr_row = row; wr_data = data; swap_req = sw;
      if (sw && sb_q.size() == 0) sb_q.push_back(((e + FRAME - 1) / FRAME) * FRAME);
      goto(e);
      wr_en = 1'b0; wr_row = 3'd0; wr_data = 16'h0; swap_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      int k, e;
      vecs[0] = '{1'b1, 3'd3, 16'h8001, 1, 1'b0, 10, 3'd3, 16'h7FFE, 1};
      vecs[1] = '{1'b0, 3'd0, 16'h0000, 0, 1'b0, 10, 3'd0, 16'hFFFF, 0};
      vecs[2] = '{1'b1, 3'd3, 16'hFFFF, 0, 1'b0, 10, 3'd3, 16'h7FFE, 0};
      vecs[3] = '{1'b0, 3'd0, 16'h0000, 0, 1'b0, 10, 3'd3, 16'h7FFE, 0};
      vecs[4] = '{1'b0, 3'd0, 16'h0000, 0, 1'b0, 10, 3'd3, 16'h7FFE, 0};
      vecs[5] = '{1'b1, 3'd0, 16'h0F0F, 1, 1'b1, 0,  3'd0, 16'hF0F0, 1};
      vecs[6] = '{1'b0, 3'd0, 16'h0000, 0, 1'b0, 10, 3'd3, 16'h0000, 0};
      vecs[7] = '{1'b0, 3'd0, 16'h0000, 3, 1'b0, 10, 3'd3, 16'h7FFE, 1};
      vecs[8] = '{1'b0, 3'd0, 16'h0000, 0, 1'b0, 10, 3'd0, 16'hFFFF, 0};
      vecs[9] = '{1'b1, 3'd3, 16'h1234, 0, 1'b0, 22, 3'd3, 16'h7FFE, 0};

      @(posedge clk); #1;
      mon_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_row", 32'(output_row), 32'(8'hFF));
      chk("rst_col", 32'(output_col), 32'(16'hFFFF));
      chk("rst_ack", 32'(swap_ack), 32'(1'b0));
      chk("rst_fs", 32'(frame_start), 32'(1'b0));
      #2 rst_n = 1'b1;

      goto(1);
      chk("first_blank_fs", 32'(frame_start), 32'(1'b0));
      chk("first_blank_row", 32'(output_row), 32'(8'hFF));
      goto(2);
      chk("first_fs", 32'(frame_start), 32'(1'b1));
      for (int r = 0; r < 8; r++) begin
         goto(2 + ROWP * r + 1);
         chk("scan_row", 32'(output_row), 32'(8'hFF ^ (8'h01 << r)));
         goto(ROWP * r + 6);
         chk("scan_gap", 32'(output_row), 32'(8'hFF));
      end

      for (int i = 0; i < NV; i++) begin
         k = 2 * i + 1;
         ack_cnt = 0;
         e = vecs[i].bnd ? FRAME * (k + 1) : FRAME * k + vecs[i].off;
         pulse(e, vecs[i].we, vecs[i].row, vecs[i].data, vecs[i].nswap > 0);
         for (int j = 1; j < vecs[i].nswap; j++) pulse(e + 12 * j, 1'b0, 3'd0, 16'h0, 1'b1);
         goto(FRAME * (k + 1) + 2 + ROWP * int'(vecs[i].chk_row) + 1);
         chk("vec_row", 32'(output_row), 32'(8'hFF ^ (8'h01 << vecs[i].chk_row)));
         chk("vec_col", 32'(output_col), 32'(vecs[i].chk_col));
         chk("vec_acks", 32'(ack_cnt), 32'(vecs[i].acks));
      end

      k = 2 * NV + 1;
      pulse(FRAME * k + 10, 1'b1, 3'd5, 16'hAAAA, 1'b1);
      goto(FRAME * k + 2 + ROWP * 5 + 1);
      chk("pre_rst_row5", 32'(output_row), 32'(8'hDF));
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_row", 32'(output_row), 32'(8'hFF));
      chk("midrst_col", 32'(output_col), 32'(16'hFFFF));
      chk("midrst_ack", 32'(swap_ack), 32'(1'b0));
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      ack_cnt = 0;
      goto(2);
      chk("post_rst_fs", 32'(frame_start), 32'(1'b1));
      for (int r = 0; r < 8; r++) begin
         goto(2 + ROWP * r + 1);
         chk("post_rst_row", 32'(output_row), 32'(8'hFF ^ (8'h01 << r)));
         chk("post_rst_col", 32'(output_col), 32'(16'hFFFF));
      end
      goto(FRAME + 4);
      chk("post_rst_no_ack", 32'(ack_cnt), 32'(0));
      chk("sb_drained", 32'(sb_q.size()), 32'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
